// File: rtl/freq_det_pkg.sv
// Shared types and constants for the period-window frequency detector.
package freq_det_pkg;

  // Default width of period samples and window bounds.
  localparam int unsigned PrdWDefault = 16;

  // Width of the match/miss counters.
  localparam int unsigned CntW = 8;

  // Width of the optional idle timer.
  localparam int unsigned TimerW = 24;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAcq    = 2'd1,
    StLocked = 2'd2
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/freq_det_timer.sv
// Idle timer: counts cycles since the last clear, saturating at Timeout.
// expire_o flags the single cycle in which the count would reach Timeout.
module freq_det_timer
  import freq_det_pkg::*;
#(
  parameter int unsigned Timeout = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic expire_o
);

  localparam logic [TimerW-1:0] TimeoutV   = TimerW'(Timeout);
  localparam logic [TimerW-1:0] TimeoutM1V = TimerW'(Timeout - 1);

  logic [TimerW-1:0] timer_q;
  logic [TimerW-1:0] timer_d;

  // Next count: restart on clear, otherwise count up and hold at Timeout.
  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (timer_q < TimeoutV) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // A clear in the same cycle always beats expiry.
  assign expire_o = !clear_i && (timer_q == TimeoutM1V);

endmodule

// File: rtl/freq_window_detector.sv
// Frequency window detector: declares lock after LOCK_CNT consecutive
// in-window period samples and drops it after LOSS_CNT consecutive misses.
// Optional idle timeout is compiled in with `define FREQ_DET_TIMEOUT_EN.
module freq_window_detector
  import freq_det_pkg::*;
#(
  parameter int unsigned PRD_W    = PrdWDefault,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned TIMEOUT  = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prd_valid,
  input  logic [PRD_W-1:0] prd,
  input  logic [PRD_W-1:0] prd_min,
  input  logic [PRD_W-1:0] prd_max,
  output logic             detected,
  output logic             lock_tick,
  output logic             loss_tick,
  output logic [PRD_W-1:0] last_prd,
  output logic             match
);

  localparam logic [CntW-1:0] LockCntV = CntW'(LOCK_CNT);
  localparam logic [CntW-1:0] LossCntV = CntW'(LOSS_CNT);

  state_e            state_q;
  logic [CntW-1:0]   match_cnt_q;
  logic [CntW-1:0]   miss_cnt_q;
  logic              detected_q;
  logic              lock_tick_q;
  logic              loss_tick_q;
  logic [PRD_W-1:0]  last_prd_q;
  logic              match_q;

  logic              hit;
  logic              timeout_expire;

  // An inverted window (min > max) can never be satisfied.
  assign hit = (prd >= prd_min) && (prd <= prd_max);

`ifdef FREQ_DET_TIMEOUT_EN
  freq_det_timer #(
    .Timeout (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (prd_valid),
    .expire_o (timeout_expire)
  );
`else
  assign timeout_expire = 1'b0;
`endif

  // FSM, counters and registered outputs; a sample always wins over timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      detected_q  <= 1'b0;
      lock_tick_q <= 1'b0;
      loss_tick_q <= 1'b0;
      last_prd_q  <= '0;
      match_q     <= 1'b0;
    end else begin
      lock_tick_q <= 1'b0;
      loss_tick_q <= 1'b0;
      if (prd_valid) begin
        last_prd_q <= prd;
        match_q    <= hit;
        unique case (state_q)
          StIdle: begin
            if (hit) begin
              state_q     <= StAcq;
              match_cnt_q <= 8'd1;
              miss_cnt_q  <= '0;
            end
          end
          StAcq: begin
            if (!hit) begin
              state_q     <= StIdle;
              match_cnt_q <= '0;
              miss_cnt_q  <= '0;
            end else if (sat_inc(match_cnt_q) == LockCntV) begin
              state_q     <= StLocked;
              match_cnt_q <= '0;
              miss_cnt_q  <= '0;
              detected_q  <= 1'b1;
              lock_tick_q <= 1'b1;
            end else begin
              match_cnt_q <= sat_inc(match_cnt_q);
            end
          end
          StLocked: begin
            if (hit) begin
              miss_cnt_q <= '0;
            end else if (sat_inc(miss_cnt_q) == LossCntV) begin
              state_q     <= StIdle;
              match_cnt_q <= '0;
              miss_cnt_q  <= '0;
              detected_q  <= 1'b0;
              loss_tick_q <= 1'b1;
            end else begin
              miss_cnt_q <= sat_inc(miss_cnt_q);
            end
          end
          default: begin
            state_q     <= StIdle;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            detected_q  <= 1'b0;
          end
        endcase
      end else if (timeout_expire && (state_q != StIdle)) begin
        loss_tick_q <= (state_q == StLocked);
        state_q     <= StIdle;
        match_cnt_q <= '0;
        miss_cnt_q  <= '0;
        detected_q  <= 1'b0;
      end
    end
  end

  assign detected  = detected_q;
  assign lock_tick = lock_tick_q;
  assign loss_tick = loss_tick_q;
  assign last_prd  = last_prd_q;
  assign match     = match_q;

endmodule

// File: tb/tb_freq_window_detector.sv
// Directed bench for freq_window_detector with a sample-history reference model.
module tb_freq_window_detector;

  localparam int PW   = 16;
  localparam int LOCK = 4;
  localparam int LOSS = 3;
  localparam int TO   = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          prd_valid = 1'b0;
  logic [PW-1:0] prd = '0;
  logic [PW-1:0] prd_min = 16'd100;
  logic [PW-1:0] prd_max = 16'd110;
  logic          detected;
  logic          lock_tick;
  logic          loss_tick;
  logic [PW-1:0] last_prd;
  logic          match;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: consecutive good samples while unlocked,
  // consecutive bad samples while locked, cycles since last sample.
  int  run    = 0;
  int  misses = 0;
  int  idle   = 0;
  bit  locked = 0;
  bit  e_det, e_lock, e_loss, e_match;
  int  e_last;

  freq_window_detector #(
    .PRD_W    (PW),
    .LOCK_CNT (LOCK),
    .LOSS_CNT (LOSS),
    .TIMEOUT  (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .prd_valid (prd_valid),
    .prd       (prd),
    .prd_min   (prd_min),
    .prd_max   (prd_max),
    .detected  (detected),
    .lock_tick (lock_tick),
    .loss_tick (loss_tick),
    .last_prd  (last_prd),
    .match     (match)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input int p);
    bit hit;
    e_lock = 0;
    e_loss = 0;
    if (r) begin
      run = 0; misses = 0; idle = 0; locked = 0;
      e_match = 0; e_last = 0;
    end else if (v) begin
      hit = (int'(prd_min) <= p) && (p <= int'(prd_max));
      e_last = p;
      e_match = hit;
      idle = 0;
      if (!locked) begin
        run = hit ? run + 1 : 0;
        if (run >= LOCK) begin
          locked = 1; e_lock = 1; run = 0; misses = 0;
        end
      end else begin
        misses = hit ? 0 : misses + 1;
        if (misses >= LOSS) begin
          locked = 0; e_loss = 1; run = 0; misses = 0;
        end
      end
    end else begin
      idle++;
`ifdef FREQ_DET_TIMEOUT_EN
      if (idle == TO && (locked || run > 0)) begin
        e_loss = locked;
        locked = 0; run = 0; misses = 0;
      end
`endif
    end
    e_det = locked;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic cyc(input bit v, input int p, input bit r = 0);
    reset = r;
    prd_valid = v;
    prd = PW'(p);
    @(posedge clk);
    model_step(r, v, p);
    #1;
    chk("detected", int'(detected), int'(e_det));
    chk("lock_tick", int'(lock_tick), int'(e_lock));
    chk("loss_tick", int'(loss_tick), int'(e_loss));
    chk("match", int'(match), int'(e_match));
    chk("last_prd", int'(last_prd), e_last);
    chk("ticks_exclusive", int'(lock_tick & loss_tick), 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0);
  endtask

  initial begin
    // Reset state
    cyc(0, 0, 1);
    cyc(1, 77, 1);
    chk("rst_detected", int'(detected), 0);
    chk("rst_last_prd", int'(last_prd), 0);
    chk("rst_match", int'(match), 0);

    // Lock on four in-window samples, with gaps in between
    cyc(1, 105); idle_cycles(2);
    cyc(1, 105); cyc(0, 0);
    cyc(1, 105);
    chk("lit_no_lock_3", int'(detected), 0);
    cyc(1, 105);
    chk("lit_lock_tick_4", int'(lock_tick), 1);
    chk("lit_det_4", int'(detected), 1);
    cyc(0, 0);
    chk("lit_lock_tick_pulse", int'(lock_tick), 0);

    // Misses must be consecutive to drop lock
    cyc(1, 111); cyc(1, 105); cyc(1, 99); cyc(1, 99);
    chk("lit_hold_2_miss", int'(detected), 1);
    cyc(1, 99);
    chk("lit_loss_tick", int'(loss_tick), 1);
    chk("lit_det_drop", int'(detected), 0);

    // Window boundaries
    cyc(1, 100); chk("lit_b100", int'(match), 1);
    cyc(1, 110); chk("lit_b110", int'(match), 1);
    cyc(1, 99);  chk("lit_b99", int'(match), 0);
    cyc(1, 111); chk("lit_b111", int'(match), 0);
    prd_min = 16'd120; prd_max = 16'd110;
    cyc(1, 115); chk("lit_inverted", int'(match), 0);
    prd_min = 16'd100; prd_max = 16'd110;

    // Abort acquisition after three hits, then lock on four fresh ones
    cyc(1, 105); cyc(1, 101); cyc(1, 109);
    cyc(1, 200);
    chk("lit_abort_no_lock", int'(lock_tick), 0);
    cyc(1, 105); cyc(1, 105); cyc(1, 105);
    chk("lit_relock_pending", int'(detected), 0);
    cyc(1, 105);
    chk("lit_relock", int'(lock_tick), 1);

    // Reset while locked with a concurrent sample
    cyc(1, 105, 1);
    chk("lit_rst_det", int'(detected), 0);
    chk("lit_rst_loss", int'(loss_tick), 0);
    chk("lit_rst_last", int'(last_prd), 0);

    // Idle behaviour while locked
    for (int i = 0; i < LOCK; i++) cyc(1, 104);
    idle_cycles(TO - 1);
    chk("lit_idle_hold", int'(detected), 1);
`ifdef FREQ_DET_TIMEOUT_EN
    cyc(0, 0);
    chk("lit_to_loss", int'(loss_tick), 1);
    chk("lit_to_det", int'(detected), 0);
    for (int i = 0; i < LOCK; i++) cyc(1, 104);
    idle_cycles(TO - 1);
    cyc(1, 106);
    chk("lit_to_race_det", int'(detected), 1);
    chk("lit_to_race_loss", int'(loss_tick), 0);
    // Acquisition also times out, silently
    idle_cycles(TO);
    cyc(1, 105); cyc(1, 105);
    idle_cycles(TO);
    cyc(1, 105);
    chk("lit_acq_to_restart", int'(detected), 0);
`else
    idle_cycles(3 * TO);
    chk("lit_persist", int'(detected), 1);
    chk("lit_persist_loss", int'(loss_tick), 0);
`endif
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_window_detector.md
FREQ_WINDOW_DETECTOR -- requirements
Module: freq_window_detector

Interface
REQ-001 Parameter PRD_W, 16, width of period samples and window bounds.
REQ-002 Parameter LOCK_CNT, 4, consecutive in-window periods needed to declare detection (legal range 2..255).
REQ-003 Parameter LOSS_CNT, 3, consecutive out-of-window periods needed to drop detection (legal range 1..255).
REQ-004 Parameter TIMEOUT, 50000, clock cycles without a period sample before detection drops (legal range 2..2^24-1).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 prd_valid  input  1  one-cycle strobe marking a new period sample, from the period-measurement stage's done tick.
REQ-008 prd  input  PRD_W  measured period in clk cycles; sampled only when prd_valid=1.
REQ-009 prd_min  input  PRD_W  inclusive lower window bound; quasi-static.
REQ-010 prd_max  input  PRD_W  inclusive upper window bound; quasi-static.
REQ-011 detected  output  1  registered level; high while in LOCKED.
REQ-012 lock_tick  output  1  one-cycle pulse on entry to LOCKED.
REQ-013 loss_tick  output  1  one-cycle pulse on exit from LOCKED.
REQ-014 last_prd  output  PRD_W  last sampled prd, registered.
REQ-015 match  output  1  registered in-window flag of the last sample.

Function
REQ-016 A sample SHALL be in-window when prd_min <= prd <= prd_max (unsigned); prd_min > prd_max SHALL make every sample out-of-window.
REQ-017 FSM states SHALL be IDLE, ACQ, LOCKED; all outputs SHALL update on the edge after the prd_valid cycle (latency 1).
REQ-018 IDLE: in-window sample -> ACQ with match_cnt=1; out-of-window sample -> stay IDLE.
REQ-019 ACQ: in-window sample increments match_cnt; reaching LOCK_CNT -> LOCKED, lock_tick=1, detected=1; out-of-window sample -> IDLE, match_cnt=0.
REQ-020 LOCKED: in-window sample clears miss_cnt; out-of-window sample increments miss_cnt; reaching LOSS_CNT -> IDLE, loss_tick=1, detected=0, counters cleared.
REQ-021 Counters SHALL be 8-bit, reset to 0 on every state change, and never wrap.
REQ-022 last_prd and match SHALL load on every prd_valid regardless of state.
REQ-023 No state change SHALL occur in cycles with prd_valid=0, except timeout (REQ-027).
REQ-024 lock_tick and loss_tick SHALL never both be high in the same cycle.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE, clear all counters and timer, and drive detected, lock_tick, loss_tick, match=0 and last_prd=0, overriding any concurrent prd_valid.
REQ-026 Reset mid-LOCKED SHALL NOT generate loss_tick.

Configuration
REQ-027 With FREQ_DET_TIMEOUT_EN defined: a 24-bit idle timer SHALL count cycles since the last prd_valid, saturating at TIMEOUT; on reaching TIMEOUT in ACQ or LOCKED the FSM SHALL go to IDLE (loss_tick=1 if it was LOCKED); prd_valid in the same cycle SHALL win, restart the timer, and be processed normally.
REQ-028 Without FREQ_DET_TIMEOUT_EN: no timer logic SHALL exist and detection SHALL persist indefinitely without samples.

Structure
REQ-029 Package freq_det_pkg SHALL hold the state enum (IDLE, ACQ, LOCKED), the default PRD_W and the counter width constant.
REQ-030 Idle timer SHALL be sub-module freq_det_timer (clear, saturate, expiry flag), instantiated only under FREQ_DET_TIMEOUT_EN.

Verification
REQ-031 Window 100..110, LOCK_CNT=4: prd 105 x4 -> lock_tick on edge after 4th strobe, detected=1.
REQ-032 Window 100..110, while LOCKED: prd 111, 105, 99, 99, 99 -> detected drops with loss_tick after the third consecutive 99 only.
REQ-033 Boundaries: prd=100 and prd=110 -> match=1; prd=99 and prd=111 -> match=0; prd_min=120, prd_max=110 with prd=115 -> match=0.
REQ-034 ACQ with match_cnt=3, then prd=200 -> IDLE, no lock_tick; next 4 in-window samples -> lock.
REQ-035 TIMEOUT=10, macro defined: lock, then 10 idle cycles -> loss_tick, detected=0; strobe landing on the expiry cycle -> stays LOCKED.
REQ-036 reset asserted while LOCKED concurrent with prd_valid -> all outputs 0 next cycle, no loss_tick.
